// File: rtl/wb_i2c_seq_pkg.sv
// Shared constants for the I2C command sequencer: I2C core register map,
// CR/SR bit positions, command opcodes and sequencer states.
package wb_i2c_seq_pkg;

    localparam logic [2:0] PRER_LO = 3'd0;
    localparam logic [2:0] PRER_HI = 3'd1;
    localparam logic [2:0] CTR     = 3'd2;
    localparam logic [2:0] TXR_RXR = 3'd3;
    localparam logic [2:0] CR_SR   = 3'd4;

    localparam int CR_STA = 7;
    localparam int CR_STO = 6;
    localparam int CR_RD  = 5;
    localparam int CR_WR  = 4;
    localparam int CR_ACK = 3;

    localparam int SR_RXACK = 7;
    localparam int SR_BUSY  = 6;
    localparam int SR_AL    = 5;
    localparam int SR_TIP   = 1;

    localparam logic [7:0] CTR_EN = 8'h80;

    typedef enum logic [2:0] {
        OP_INIT         = 3'd0,
        OP_START_WR     = 3'd1,
        OP_WR           = 3'd2,
        OP_RD_ACK       = 3'd3,
        OP_RD_NACK      = 3'd4,
        OP_STOP         = 3'd5,
        OP_WR_STOP      = 3'd6,
        OP_RD_NACK_STOP = 3'd7
    } cmd_op_e;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_PRE_LO = 4'd1,
        S_PRE_HI = 4'd2,
        S_CTR    = 4'd3,
        S_TXR    = 4'd4,
        S_CR     = 4'd5,
        S_POLL   = 4'd6,
        S_RXR    = 4'd7,
        S_RESP   = 4'd8
    } state_e;

    function automatic logic is_wr_op(cmd_op_e op);
        return op inside {OP_START_WR, OP_WR, OP_WR_STOP};
    endfunction

    function automatic logic is_rd_op(cmd_op_e op);
        return op inside {OP_RD_ACK, OP_RD_NACK, OP_RD_NACK_STOP};
    endfunction

    function automatic logic [7:0] cr_for_op(cmd_op_e op);
        logic [7:0] cr;
        cr = 8'h00;
        case (op)
            OP_START_WR:     begin cr[CR_STA] = 1'b1; cr[CR_WR] = 1'b1; end
            OP_WR:           cr[CR_WR] = 1'b1;
            OP_WR_STOP:      begin cr[CR_STO] = 1'b1; cr[CR_WR] = 1'b1; end
            OP_RD_ACK:       cr[CR_RD] = 1'b1;
            OP_RD_NACK:      begin cr[CR_RD] = 1'b1; cr[CR_ACK] = 1'b1; end
            OP_RD_NACK_STOP: begin cr[CR_STO] = 1'b1; cr[CR_RD] = 1'b1; cr[CR_ACK] = 1'b1; end
            OP_STOP:         cr[CR_STO] = 1'b1;
            default:         cr = 8'h00;
        endcase
        return cr;
    endfunction

endpackage

// File: rtl/wb_single_xfer.sv
// One-shot Wishbone master: a req pulse launches one access, done pulses the
// cycle after ACK with the captured read data.
module wb_single_xfer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_i,
    input  logic [2:0] addr_i,
    input  logic [7:0] wdata_i,
    input  logic       we_i,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    input  logic       wb_ack_i
);

    logic       stb_q;
    logic [2:0] adr_q;
    logic [7:0] dat_q;
    logic       we_q;
    logic [7:0] rdata_q;
    logic       done_q;

    // req is ignored while an access is open; the requester waits for done.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stb_q   <= 1'b0;
            adr_q   <= 3'd0;
            dat_q   <= 8'h00;
            we_q    <= 1'b0;
            rdata_q <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (stb_q) begin
                if (wb_ack_i) begin
                    stb_q   <= 1'b0;
                    rdata_q <= wb_dat_i;
                    done_q  <= 1'b1;
                end
            end else if (req_i) begin
                stb_q <= 1'b1;
                adr_q <= addr_i;
                dat_q <= wdata_i;
                we_q  <= we_i;
            end
        end
    end

    assign done_o   = done_q;
    assign rdata_o  = rdata_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_we_o  = we_q;
    assign wb_stb_o = stb_q;
    assign wb_cyc_o = stb_q;

endmodule

// File: rtl/wb_i2c_cmd_sequencer.sv
// Turns byte-level I2C commands into I2C master core register sequences
// (init, TXR/CR writes, SR polling, RXR read) and returns one response each.
module wb_i2c_cmd_sequencer
    import wb_i2c_seq_pkg::*;
#(
    parameter logic [15:0] PRESCALE   = 16'h00C7,
    parameter logic [15:0] POLL_LIMIT = 16'd4096
) (
    input  logic       WB_CLK_I,
    input  logic       ARST_I,
    input  logic       CMD_VALID_I,
    output logic       CMD_READY_O,
    input  logic [2:0] CMD_OP_I,
    input  logic [7:0] CMD_DATA_I,
    output logic       RSP_VALID_O,
    input  logic       RSP_READY_I,
    output logic [7:0] RSP_DATA_O,
    output logic       RSP_NACK_O,
    output logic       RSP_AL_O,
    output logic       RSP_TMO_O,
    output logic       BUSY_O,
    output logic [2:0] WB_ADR_O,
    output logic [7:0] WB_DAT_O,
    input  logic [7:0] WB_DAT_I,
    output logic       WB_WE_O,
    output logic       WB_STB_O,
    output logic       WB_CYC_O,
    input  logic       WB_ACK_I
);

    state_e     state_q, state_d;
    cmd_op_e    op_q, op_d, cmd_op;
    logic [7:0] data_q, data_d;
    logic       pend_q, pend_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       nack_q, nack_d;
    logic       al_q, al_d;
    logic       tmo_q, tmo_d;
    logic       rdy_en_q;

    logic       x_req, x_we, x_done, acc;
    logic [2:0] x_addr;
    logic [7:0] x_wdata, x_rdata;
    logic       accept, poll_exit;

    assign cmd_op  = cmd_op_e'(CMD_OP_I);
    assign accept  = CMD_VALID_I && CMD_READY_O;
    assign cnt_inc = cnt_q + 16'd1;
    assign acc     = state_q inside {S_PRE_LO, S_PRE_HI, S_CTR, S_TXR, S_CR, S_POLL, S_RXR};
    assign poll_exit = (op_q == OP_STOP) ? !x_rdata[SR_BUSY] : !x_rdata[SR_TIP];

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        nack_d     = nack_q;
        al_d       = al_q;
        tmo_d      = tmo_q;
        x_addr     = CR_SR;
        x_wdata    = 8'h00;
        x_we       = 1'b0;
        case (state_q)
            S_IDLE: if (accept) begin
                op_d       = cmd_op;
                data_d     = CMD_DATA_I;
                cnt_d      = 16'd0;
                rsp_data_d = 8'h00;
                nack_d     = 1'b0;
                al_d       = 1'b0;
                tmo_d      = 1'b0;
                if (cmd_op == OP_INIT)
                    state_d = S_PRE_LO;
                else if (is_wr_op(cmd_op))
                    state_d = S_TXR;
                else
                    state_d = S_CR;
            end
            S_PRE_LO: begin
                x_addr = PRER_LO; x_wdata = PRESCALE[7:0]; x_we = 1'b1;
                if (x_done) state_d = S_PRE_HI;
            end
            S_PRE_HI: begin
                x_addr = PRER_HI; x_wdata = PRESCALE[15:8]; x_we = 1'b1;
                if (x_done) state_d = S_CTR;
            end
            S_CTR: begin
                x_addr = CTR; x_wdata = CTR_EN; x_we = 1'b1;
                if (x_done) state_d = S_RESP;
            end
            S_TXR: begin
                x_addr = TXR_RXR; x_wdata = data_q; x_we = 1'b1;
                if (x_done) state_d = S_CR;
            end
            S_CR: begin
                x_addr = CR_SR; x_wdata = cr_for_op(op_q); x_we = 1'b1;
                if (x_done) state_d = S_POLL;
            end
            // AL wins over the normal exit; the limit only applies when neither hit.
            S_POLL: if (x_done) begin
                cnt_d = cnt_inc;
                if (x_rdata[SR_AL]) begin
                    al_d    = 1'b1;
                    state_d = S_RESP;
                end else if (poll_exit) begin
                    nack_d  = is_wr_op(op_q) ? x_rdata[SR_RXACK] : 1'b0;
                    state_d = is_rd_op(op_q) ? S_RXR : S_RESP;
                end else if (cnt_inc == POLL_LIMIT) begin
                    tmo_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RXR: begin
                x_addr = TXR_RXR;
                if (x_done) begin
                    rsp_data_d = x_rdata;
                    state_d    = S_RESP;
                end
            end
            S_RESP: if (RSP_READY_I) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One request per access state; pend blocks re-issue until done returns.
    assign x_req = acc && !pend_q;
    always_comb begin
        pend_d = pend_q;
        if (x_done)
            pend_d = 1'b0;
        else if (x_req)
            pend_d = 1'b1;
    end

    always_ff @(posedge WB_CLK_I or posedge ARST_I) begin
        if (ARST_I) begin
            state_q    <= S_IDLE;
            op_q       <= OP_INIT;
            data_q     <= 8'h00;
            pend_q     <= 1'b0;
            cnt_q      <= 16'd0;
            rsp_data_q <= 8'h00;
            nack_q     <= 1'b0;
            al_q       <= 1'b0;
            tmo_q      <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            nack_q     <= nack_d;
            al_q       <= al_d;
            tmo_q      <= tmo_d;
            rdy_en_q   <= 1'b1;
        end
    end

    wb_single_xfer u_xfer (
        .clk_i    (WB_CLK_I),
        .rst_i    (ARST_I),
        .req_i    (x_req),
        .addr_i   (x_addr),
        .wdata_i  (x_wdata),
        .we_i     (x_we),
        .done_o   (x_done),
        .rdata_o  (x_rdata),
        .wb_adr_o (WB_ADR_O),
        .wb_dat_o (WB_DAT_O),
        .wb_dat_i (WB_DAT_I),
        .wb_we_o  (WB_WE_O),
        .wb_stb_o (WB_STB_O),
        .wb_cyc_o (WB_CYC_O),
        .wb_ack_i (WB_ACK_I)
    );

    assign CMD_READY_O = rdy_en_q && (state_q == S_IDLE);
    assign BUSY_O      = (state_q != S_IDLE);
    assign RSP_VALID_O = (state_q == S_RESP);
    assign RSP_DATA_O  = rsp_data_q;
    assign RSP_NACK_O  = nack_q;
    assign RSP_AL_O    = al_q;
    assign RSP_TMO_O   = tmo_q;

endmodule
